// File: rtl/capi_get_cmd_split_pkg.sv
// Shared constants and FSM state type for the CAPI get-command path.
package capi_get_cmd_split_pkg;
  localparam int CL_BYTES = 128;
  localparam int CL_OFS_W = 7;

  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/base_alatch.sv
// One-entry valid/ready holding register; load and drain in the same cycle.
// Latency 1 cycle; accepts new data whenever empty or being drained.
module base_alatch #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             o_r,
  input  logic [width-1:0] i_d,
  output logic             o_v,
  input  logic             i_r,
  output logic [width-1:0] o_d
);
  assign o_r = ~o_v | i_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_v <= 1'b0;
      o_d <= '0;
    end else if (i_v & o_r) begin
      o_v <= 1'b1;
      o_d <= i_d;
    end else if (i_r) begin
      o_v <= 1'b0;
    end
  end
endmodule

// File: rtl/capi_cl_count.sv
// Combinational: byte offset in first line + length -> 128B line count and end offset.
// Shared with the put path.
module capi_cl_count
  import capi_get_cmd_split_pkg::*;
#(
  parameter int len_width = 24,
  parameter int cnt_width = len_width - 5
) (
  input  logic [CL_OFS_W-1:0]  ofs,
  input  logic [len_width-1:0] len,
  output logic [cnt_width-1:0] cnt,
  output logic [CL_OFS_W-1:0]  end_ofs
);
  localparam int SUM_W = len_width + 2;

  logic [SUM_W-1:0] sum;

  // Round the touched byte span up to whole lines.
  assign sum     = SUM_W'(ofs) + SUM_W'(len) + SUM_W'(CL_BYTES - 1);
  assign cnt     = cnt_width'(sum >> CL_OFS_W);
  assign end_ofs = ofs + len[CL_OFS_W-1:0];
endmodule

// File: rtl/capi_get_cmd_split.sv
// Splits a get request {ea, len} into 128B read-line commands, one buffer tag per line.
// Accept N -> first take N+1 -> o_cmd_v N+2; takes stall while the single command slot is held.
module capi_get_cmd_split
  import capi_get_cmd_split_pkg::*;
#(
  parameter int                   ea_width      = 64,
  parameter int                   len_width     = 24,
  parameter int                   uid_width     = 1,
  parameter logic [uid_width-1:0] uid           = '0,
  parameter int                   lcl_tag_width = 4,
  parameter int                   cnt_width     = len_width - 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_disable,
  input  logic                               i_req_v,
  output logic                               i_req_r,
  input  logic [ea_width-1:0]                i_req_ea,
  input  logic [len_width-1:0]               i_req_len,
  input  logic                               i_tag_v,
  output logic                               o_tag_r,
  input  logic [lcl_tag_width-1:0]           i_tag_d,
  input  logic                               i_tag_f,
  output logic                               o_tag_e,
  output logic [CL_OFS_W-1:0]                o_tag_ea_lsb,
  output logic [CL_OFS_W-1:0]                o_tag_ea_lsb_nxt,
  output logic                               o_cmd_v,
  input  logic                               i_cmd_r,
  output logic [uid_width+lcl_tag_width-1:0] o_cmd_tag,
  output logic [ea_width-1:0]                o_cmd_ea,
  output logic                               o_busy,
  output logic                               o_len_err,
  output logic                               o_seq_err
);
  localparam int LINE_W = ea_width - CL_OFS_W;
  localparam int TAG_W  = uid_width + lcl_tag_width;
  localparam int CMD_W  = TAG_W + ea_width;

  state_t               state, state_nxt;
  logic [LINE_W-1:0]    line;
  logic                 first;
  logic [cnt_width-1:0] rem;
  logic [CL_OFS_W-1:0]  st, nd;

  logic                 req_acc, req_zero, take, cmd_rdy;
  logic [cnt_width-1:0] req_cnt;
  logic [CL_OFS_W-1:0]  req_nd;
  logic [CMD_W-1:0]     cmd_d, cmd_q;

  capi_cl_count #(
    .len_width (len_width),
    .cnt_width (cnt_width)
  ) u_cl_count (
    .ofs     (i_req_ea[CL_OFS_W-1:0]),
    .len     (i_req_len),
    .cnt     (req_cnt),
    .end_ofs (req_nd)
  );

  assign i_req_r  = (state == IDLE) & ~i_disable;
  assign req_acc  = i_req_v & i_req_r;
  assign req_zero = (i_req_len == '0);

  assign take             = (state == RUN) & i_tag_v & cmd_rdy;
  assign o_tag_r          = take;
  assign o_tag_e          = (rem == cnt_width'(1));
  assign o_tag_ea_lsb     = first ? st : '0;
  assign o_tag_ea_lsb_nxt = o_tag_e ? nd : '0;
  assign o_busy           = (state == RUN) | o_cmd_v;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_acc & ~req_zero) state_nxt = RUN;
      RUN:  if (take & o_tag_e)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line      <= '0;
      first     <= 1'b0;
      rem       <= '0;
      st        <= '0;
      nd        <= '0;
      o_len_err <= 1'b0;
      o_seq_err <= 1'b0;
    end else begin
      o_len_err <= req_acc & req_zero;
      o_seq_err <= take & (i_tag_f != first);
      if (req_acc & ~req_zero) begin
        line  <= i_req_ea[ea_width-1:CL_OFS_W];
        first <= 1'b1;
        rem   <= req_cnt;
        st    <= i_req_ea[CL_OFS_W-1:0];
        nd    <= req_nd;
      end else if (take) begin
        // Line address wraps past the top of the address space by design.
        line  <= line + LINE_W'(1);
        rem   <= rem - cnt_width'(1);
        first <= 1'b0;
      end
    end
  end

  assign cmd_d = {uid, i_tag_d, line, {CL_OFS_W{1'b0}}};

  base_alatch #(
    .width (CMD_W)
  ) u_cmd_latch (
    .clk   (clk),
    .reset (reset),
    .i_v   (take),
    .o_r   (cmd_rdy),
    .i_d   (cmd_d),
    .o_v   (o_cmd_v),
    .i_r   (i_cmd_r),
    .o_d   (cmd_q)
  );

  assign o_cmd_tag = cmd_q[CMD_W-1:ea_width];
  assign o_cmd_ea  = cmd_q[ea_width-1:0];
endmodule

// File: tb/tb_capi_get_cmd_split.sv
// Scoreboard bench for capi_get_cmd_split: per-line take and command expectations queued at request time.
module tb_capi_get_cmd_split;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_disable = 1'b0;
  logic        i_req_v = 1'b0;
  logic        i_req_r;
  logic [63:0] i_req_ea = '0;
  logic [23:0] i_req_len = '0;
  logic        i_tag_v = 1'b1;
  logic        o_tag_r;
  logic [3:0]  i_tag_d;
  logic        i_tag_f;
  logic        o_tag_e;
  logic [6:0]  o_tag_ea_lsb, o_tag_ea_lsb_nxt;
  logic        o_cmd_v;
  logic        i_cmd_r = 1'b1;
  logic [4:0]  o_cmd_tag;
  logic [63:0] o_cmd_ea;
  logic        o_busy, o_len_err, o_seq_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] lsb;
    logic [6:0] nxt;
    logic       e;
  } take_t;

  take_t       exp_take[$];
  logic [63:0] exp_cmd[$];
  logic [3:0]  tag_q[$];

  logic [3:0] tag_ctr = '0;
  logic       first_pending = 1'b0;
  logic       flip_f = 1'b0;
  logic       mon_en = 1'b1;

  assign i_tag_d = tag_ctr;
  assign i_tag_f = first_pending ^ flip_f;

  always #5 clk = ~clk;

  capi_get_cmd_split dut (
    .clk              (clk),
    .reset            (reset),
    .i_disable        (i_disable),
    .i_req_v          (i_req_v),
    .i_req_r          (i_req_r),
    .i_req_ea         (i_req_ea),
    .i_req_len        (i_req_len),
    .i_tag_v          (i_tag_v),
    .o_tag_r          (o_tag_r),
    .i_tag_d          (i_tag_d),
    .i_tag_f          (i_tag_f),
    .o_tag_e          (o_tag_e),
    .o_tag_ea_lsb     (o_tag_ea_lsb),
    .o_tag_ea_lsb_nxt (o_tag_ea_lsb_nxt),
    .o_cmd_v          (o_cmd_v),
    .i_cmd_r          (i_cmd_r),
    .o_cmd_tag        (o_cmd_tag),
    .o_cmd_ea         (o_cmd_ea),
    .o_busy           (o_busy),
    .o_len_err        (o_len_err),
    .o_seq_err        (o_seq_err)
  );

  // Tag manager model: fresh tag per take, first flag raised for each new stream.
  always @(posedge clk) begin
    if (reset) begin
      first_pending <= 1'b0;
    end else begin
      if (o_tag_r) tag_ctr <= tag_ctr + 4'd1;
      if (i_req_v && i_req_r && i_req_len != 0) first_pending <= 1'b1;
      else if (o_tag_r) first_pending <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (o_tag_r) begin
        checks++;
        if (exp_take.size() == 0) begin
          errors++;
          $display("FAIL take_unexpected: got take lsb=%h nxt=%h e=%b, required no take",
                   o_tag_ea_lsb, o_tag_ea_lsb_nxt, o_tag_e);
        end else begin
          take_t t;
          t = exp_take.pop_front();
          if (o_tag_ea_lsb !== t.lsb || o_tag_ea_lsb_nxt !== t.nxt || o_tag_e !== t.e) begin
            errors++;
            $display("FAIL take_fields: got lsb=%h nxt=%h e=%b, required lsb=%h nxt=%h e=%b",
                     o_tag_ea_lsb, o_tag_ea_lsb_nxt, o_tag_e, t.lsb, t.nxt, t.e);
          end
        end
        tag_q.push_back(i_tag_d);
      end
      if (o_cmd_v && i_cmd_r) begin
        checks++;
        if (exp_cmd.size() == 0 || tag_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got ea=%h tag=%h, required no command", o_cmd_ea, o_cmd_tag);
        end else begin
          logic [63:0] ea;
          logic [3:0]  tg;
          ea = exp_cmd.pop_front();
          tg = tag_q.pop_front();
          if (o_cmd_ea !== ea || o_cmd_tag !== {1'b0, tg}) begin
            errors++;
            $display("FAIL cmd_fields: got ea=%h tag=%h, required ea=%h tag=%h",
                     o_cmd_ea, o_cmd_tag, ea, {1'b0, tg});
          end
        end
      end
    end
  end

  // Queue per-line expectations and present the request for one accepting cycle.
  task automatic do_req(input logic [63:0] ea, input logic [23:0] len);
    int n;
    int waited;
    logic [63:0] end_ea;
    n = (int'(ea[6:0]) + int'(len) + 127) / 128;
    end_ea = ea + 64'(len);
    for (int k = 0; k < n; k++) begin
      take_t t;
      t.lsb = (k == 0) ? ea[6:0] : 7'd0;
      t.e   = (k == n - 1);
      t.nxt = t.e ? end_ea[6:0] : 7'd0;
      exp_take.push_back(t);
      exp_cmd.push_back(((ea >> 7) + 64'(k)) << 7);
    end
    waited = 0;
    @(negedge clk);
    while (!i_req_r && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!i_req_r) begin
      errors++;
      $display("FAIL req_ready_timeout: got i_req_r=%b, required 1", i_req_r);
    end
    i_req_v = 1'b1;
    i_req_ea = ea;
    i_req_len = len;
    @(posedge clk);
    #1 i_req_v = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int waited = 0;
    while ((exp_take.size() != 0 || exp_cmd.size() != 0 || o_busy) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (exp_take.size() != 0 || exp_cmd.size() != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got pending takes=%0d cmds=%0d busy=%b, required 0 0 0",
               name, exp_take.size(), exp_cmd.size(), o_busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_cmd_v, o_tag_r, i_req_r, o_busy, o_len_err, o_seq_err} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_state: got cmd_v,tag_r,req_r,busy,len_err,seq_err=%b, required 001000",
               {o_cmd_v, o_tag_r, i_req_r, o_busy, o_len_err, o_seq_err});
    end
  endtask

  task automatic test_single_line();
    do_req(64'h1000, 24'h80);
    @(negedge clk);
    checks++;
    if (o_tag_r !== 1'b1 || o_cmd_v !== 1'b0) begin
      errors++;
      $display("FAIL single_take_latency: got tag_r=%b cmd_v=%b, required 1 0", o_tag_r, o_cmd_v);
    end
    @(negedge clk);
    checks++;
    if (o_cmd_v !== 1'b1 || o_seq_err !== 1'b0) begin
      errors++;
      $display("FAIL single_cmd_latency: got cmd_v=%b seq_err=%b, required 1 0", o_cmd_v, o_seq_err);
    end
    wait_drain("single");
  endtask

  task automatic test_multi_line();
    do_req(64'h1010, 24'h100);
    wait_drain("multi");
    do_req(64'h107F, 24'h1);
    wait_drain("last_byte");
  endtask

  task automatic test_len_zero();
    do_req(64'h2000, 24'h0);
    @(negedge clk);
    checks++;
    if (o_len_err !== 1'b1 || o_busy !== 1'b0 || o_tag_r !== 1'b0) begin
      errors++;
      $display("FAIL len_err_pulse: got len_err=%b busy=%b tag_r=%b, required 1 0 0",
               o_len_err, o_busy, o_tag_r);
    end
    @(negedge clk);
    checks++;
    if (o_len_err !== 1'b0 || i_req_r !== 1'b1) begin
      errors++;
      $display("FAIL len_err_clear: got len_err=%b req_r=%b, required 0 1", o_len_err, i_req_r);
    end
  endtask

  task automatic test_back_to_back();
    int stalled_takes = 0;
    int resumed_takes = 0;
    i_cmd_r = 1'b0;
    do_req(64'h2000, 24'h200);
    @(negedge clk);
    checks++;
    if (o_tag_r !== 1'b1) begin
      errors++;
      $display("FAIL stall_first_take: got tag_r=%b, required 1", o_tag_r);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_tag_r !== 1'b0 || o_cmd_v !== 1'b1) stalled_takes++;
    end
    checks++;
    if (stalled_takes != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d stall cycles with a take or no held cmd, required 0", stalled_takes);
    end
    @(posedge clk);
    #1 i_cmd_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_tag_r === 1'b1) resumed_takes++;
    end
    checks++;
    if (resumed_takes != 3) begin
      errors++;
      $display("FAIL back_to_back: got %0d takes in 3 cycles, required 3", resumed_takes);
    end
    wait_drain("b2b");
  endtask

  task automatic test_wrap();
    do_req(64'hFFFF_FFFF_FFFF_FF80, 24'h100);
    wait_drain("wrap");
  endtask

  task automatic test_disable();
    @(posedge clk);
    #1 i_disable = 1'b1;
    @(negedge clk);
    checks++;
    if (i_req_r !== 1'b0) begin
      errors++;
      $display("FAIL disable_ready: got i_req_r=%b, required 0", i_req_r);
    end
    #1 i_disable = 1'b0;
    do_req(64'h5040, 24'h140);
    #1 i_disable = 1'b1;
    wait_drain("disable_stream");
    #1 i_disable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int late_takes = 0;
    do_req(64'h3000, 24'h200);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    exp_take.delete();
    exp_cmd.delete();
    tag_q.delete();
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_cmd_v !== 1'b0 || i_req_r !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: got cmd_v=%b req_r=%b busy=%b, required 0 1 0",
               o_cmd_v, i_req_r, o_busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (o_tag_r !== 1'b0) late_takes++;
      @(negedge clk);
    end
    checks++;
    if (late_takes != 0) begin
      errors++;
      $display("FAIL reset_mid_no_take: got %0d takes after reset, required 0", late_takes);
    end
  endtask

  task automatic test_seq_err();
    flip_f = 1'b1;
    do_req(64'h4000, 24'h80);
    @(negedge clk);
    checks++;
    if (o_tag_r !== 1'b1) begin
      errors++;
      $display("FAIL seq_take: got tag_r=%b, required 1", o_tag_r);
    end
    @(negedge clk);
    checks++;
    if (o_seq_err !== 1'b1) begin
      errors++;
      $display("FAIL seq_err_pulse: got seq_err=%b, required 1", o_seq_err);
    end
    @(negedge clk);
    checks++;
    if (o_seq_err !== 1'b0) begin
      errors++;
      $display("FAIL seq_err_clear: got seq_err=%b, required 0", o_seq_err);
    end
    flip_f = 1'b0;
    wait_drain("seq");
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_multi_line();
    test_len_zero();
    test_back_to_back();
    test_wrap();
    test_disable();
    test_reset_mid();
    test_seq_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
